op_program_sequencer: RTL and testbench

//  Host-side controller for fsm_design (N=64, N_width=4). Holds a small program of 2-bit op codes.
//  On go it starts the datapath, streams 16 operand nibble pairs, issues one op per cycle,

---
 rtl/op_program_sequencer.sv | 172 +++++++++++++++++
 tb/tb_op_program_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : op_program_sequencer
// Brief    : Host-side program sequencer for the fsm_design datapath: loads
//            operands, issues program ops, drains to OUTPUT, gathers result.
// Revision : 1.0
// ============================================================================
module op_program_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int N          = 64,
    parameter int N_WIDTH    = 4,
    parameter int DRAIN_MAX  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [1:0]                    prog_data,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          go,
    input  logic                          opnd_valid,
    output logic                          opnd_ready,
    input  logic [N_WIDTH-1:0]            opnd_a,
    input  logic [N_WIDTH-1:0]            opnd_b,
    output logic                          busy,
    output logic                          result_valid,
    output logic [N-1:0]                  result,
    output logic                          err,
    output logic                          dp_start,
    output logic                          dp_input_enable,
    output logic [N_WIDTH-1:0]            dp_a,
    output logic [N_WIDTH-1:0]            dp_b,
    output logic [1:0]                    dp_op_val,
    input  logic [3:0]                    dp_state,
    input  logic                          dp_output_valid,
    input  logic [N_WIDTH-1:0]            dp_out
);

    localparam int c_AW    = $clog2(PROG_DEPTH);
    localparam int c_BEATS = N / N_WIDTH;
    localparam int c_BW    = $clog2(c_BEATS);
    localparam int c_DW    = $clog2(DRAIN_MAX + 1);

    localparam logic [c_BW-1:0] c_BEAT_LAST  = c_BW'(c_BEATS - 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(DRAIN_MAX - 1);

    localparam logic [3:0] c_DP_S0     = 4'd0;
    localparam logic [3:0] c_DP_S4     = 4'd4;
    localparam logic [3:0] c_DP_IDLE   = 4'd8;
    localparam logic [3:0] c_DP_INPUT  = 4'd9;
    localparam logic [3:0] c_DP_OUTPUT = 4'd10;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_RUN   = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [1:0]        r_mem [PROG_DEPTH];
    logic [c_AW-1:0]   r_pc;
    logic [c_AW:0]     r_len;
    logic [c_BW-1:0]   r_beat;
    logic [c_DW-1:0]   r_drain;
    logic [N-1:0]      r_result;
    logic              r_err;

    assign busy         = (r_state != c_ST_IDLE);
    assign result_valid = (r_state == c_ST_DONE);
    assign result       = r_result;
    assign err          = r_err;

    always_comb begin
        w_next_state    = r_state;
        dp_start        = 1'b0;
        opnd_ready      = 1'b0;
        dp_input_enable = 1'b0;
        dp_op_val       = 2'd0;
        dp_a            = '0;
        dp_b            = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (go) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                dp_start     = 1'b1;
                w_next_state = (dp_state != c_DP_IDLE) ? c_ST_IDLE : c_ST_LOAD;
            end
            c_ST_LOAD: begin
                // Operands only reach the datapath while loading, so every port idles at 0 otherwise.
                opnd_ready      = (dp_state == c_DP_INPUT);
                dp_input_enable = opnd_valid & opnd_ready;
                dp_a            = opnd_a;
                dp_b            = opnd_b;
                if (dp_input_enable && (r_beat == c_BEAT_LAST))
                    w_next_state = (r_len == '0) ? c_ST_DRAIN : c_ST_RUN;
            end
            c_ST_RUN: begin
                dp_op_val = r_mem[r_pc];
                if ({1'b0, r_pc} == (r_len - 1'b1)) w_next_state = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (dp_state == c_DP_S0)      dp_op_val = 2'd2;
                else if (dp_state == c_DP_S4) dp_op_val = 2'd1;
                if (dp_state != c_DP_OUTPUT) begin
                    if (r_drain == c_DRAIN_LAST) w_next_state = c_ST_IDLE;
                end else if (dp_output_valid && (r_beat == c_BEAT_LAST)) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_pc     <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_drain  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) r_mem[i] <= 2'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_IDLE: begin
                    if (prog_we) r_mem[prog_addr] <= prog_data;
                    if (go) begin
                        r_len   <= prog_len;
                        r_err   <= 1'b0;
                        r_pc    <= '0;
                        r_beat  <= '0;
                        r_drain <= '0;
                    end
                end
                c_ST_START: begin
                    if (dp_state != c_DP_IDLE) r_err <= 1'b1;
                end
                c_ST_LOAD: begin
                    if (dp_input_enable)
                        r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + 1'b1;
                end
                c_ST_RUN: begin
                    if (w_next_state == c_ST_RUN) r_pc <= r_pc + 1'b1;
                end
                c_ST_DRAIN: begin
                    // Only cycles spent outside OUTPUT count toward the drain timeout.
                    if (dp_state != c_DP_OUTPUT) begin
                        if (r_drain == c_DRAIN_LAST) r_err <= 1'b1;
                        else                         r_drain <= r_drain + 1'b1;
                    end else if (dp_output_valid) begin
                        r_result[r_beat*N_WIDTH +: N_WIDTH] <= dp_out;
                        if (r_beat != c_BEAT_LAST) r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_program_sequencer
// Brief    : Bench with a behavioural datapath stub and a run-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_op_program_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [1:0]  prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        go = 1'b0;
    logic        opnd_valid = 1'b0;
    logic        opnd_ready;
    logic [3:0]  opnd_a = '0, opnd_b = '0;
    logic        busy, result_valid, err;
    logic [63:0] result;
    logic        dp_start, dp_input_enable;
    logic [3:0]  dp_a, dp_b;
    logic [1:0]  dp_op_val;
    logic [3:0]  dp_state;
    logic        dp_output_valid;
    logic [3:0]  dp_out;

    always #5 clk = ~clk;

    op_program_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .go(go),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy),
        .result_valid(result_valid), .result(result), .err(err),
        .dp_start(dp_start), .dp_input_enable(dp_input_enable),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op_val(dp_op_val),
        .dp_state(dp_state), .dp_output_valid(dp_output_valid), .dp_out(dp_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Datapath semantics shared by the stub and the run predictor (S0..S7=0..7, OUTPUT=10).
    function automatic void dp_step(input logic [1:0] op, inout int s, inout logic [63:0] r,
                                    input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd0: if (s > 0) s = s - 1;
            2'd1: begin r = r + b; if (s == 4) s = 10; end
            2'd2: begin r = r ^ b; if (s == 0) s = 4; end
            default: begin r = r + (a << 1); s = 1; end
        endcase
    endfunction

    int          st;
    int          k;
    logic [63:0] sa, sb, sres;
    logic        freeze_s2 = 1'b0;
    logic        ov_input  = 1'b0;
    logic        stub_clr  = 1'b0;

    assign dp_state = (freeze_s2 && st < 8) ? 4'd2 :
                      (ov_input && st == 8) ? 4'd9 : 4'(st);
    assign dp_output_valid = (st == 10);
    assign dp_out = sres[k*4 +: 4];

    always @(posedge clk or negedge rst) begin : stub
        int ns;
        logic [63:0] nr, na, nb;
        if (!rst || stub_clr) begin
            st <= 8; k <= 0; sa <= '0; sb <= '0; sres <= '0;
        end else begin
            case (st)
                8: if (dp_start && !ov_input) begin st <= 9; k <= 0; end
                9: if (dp_input_enable) begin
                    na = sa; na[k*4 +: 4] = dp_a;
                    nb = sb; nb[k*4 +: 4] = dp_b;
                    sa <= na; sb <= nb;
                    if (k == 15) begin st <= 0; k <= 0; sres <= na; end
                    else k <= k + 1;
                end
                10: if (k == 15) begin st <= 8; k <= 0; end else k <= k + 1;
                default: if (st < 8) begin
                    ns = st; nr = sres;
                    dp_step(dp_op_val, ns, nr, sa, sb);
                    st <= ns; sres <= nr;
                end
            endcase
        end
    end

    logic [1:0]  shadow [16];
    logic [63:0] exp_result = '0;
    logic [1:0]  exp_ops [$];
    logic [1:0]  obs_ops [$];
    int          ie_count = 0;
    int          rv_count = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_quiet", {busy, opnd_ready, result_valid, err, dp_start, dp_input_enable,
                                  dp_a, dp_b, dp_op_val, result}, '0);
        end else begin
            check("ie_is_handshake", dp_input_enable, opnd_valid & opnd_ready);
            if (opnd_ready) check("ready_only_in_input", dp_state, 4'd9);
            if (dp_input_enable) begin
                ie_count++;
                check("dp_ab_passthru", {dp_a, dp_b}, {opnd_a, opnd_b});
            end
            if (!busy) check("idle_quiet", {dp_start, opnd_ready, dp_input_enable, dp_op_val, result_valid}, '0);
            if (busy && dp_state < 4'd8) obs_ops.push_back(dp_op_val);
            if (result_valid) begin
                rv_count++;
                check("result_at_valid", result, exp_result);
            end
        end
    end

    task automatic predict(input logic [63:0] a, input logic [63:0] b, input int len);
        int s = 0;
        logic [63:0] r = a;
        logic [1:0] op;
        exp_ops.delete();
        for (int i = 0; i < len; i++) begin
            exp_ops.push_back(shadow[i]);
            dp_step(shadow[i], s, r, a, b);
        end
        for (int g = 0; g < 8 && s != 10; g++) begin
            op = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
            exp_ops.push_back(op);
            dp_step(op, s, r, a, b);
        end
        exp_result = r;
    endtask

    // All driving tasks start and end at negedge+2.
    task automatic prog_write(input logic [3:0] addr, input logic [1:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        shadow[addr] = data;
        @(negedge clk); #2;
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int len, input bit wr, input logic [3:0] wa, input logic [1:0] wd);
        go = 1'b1; prog_len = 5'(len);
        if (wr) begin prog_we = 1'b1; prog_addr = wa; prog_data = wd; end
        @(negedge clk); #2;
        go = 1'b0; prog_we = 1'b0;
        #1 check("err_clear_on_go", err, 1'b0);
        check("busy_after_go", busy, 1'b1);
        #1;
    endtask

    task automatic drive_beats(input logic [63:0] a, input logic [63:0] b, input int stall1,
                               input int stall2, input int n_beats, input bit poke);
        int guard;
        for (int i = 0; i < n_beats; i++) begin
            if (i == stall1 || i == stall2) begin
                opnd_valid = 1'b0;
                repeat (3) begin
                    #1 check("stall_no_ie", dp_input_enable, 1'b0);
                    @(negedge clk); #2;
                end
            end
            opnd_valid = 1'b1; opnd_a = a[i*4 +: 4]; opnd_b = b[i*4 +: 4];
            if (poke && i == 3) begin
                go = 1'b1; prog_len = 5'd0;
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = ~shadow[0];
            end
            guard = 0;
            #1;
            while (!opnd_ready && guard < 50) begin
                @(negedge clk); #3; guard++;
            end
            if (guard == 50) check("ready_timeout", 1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk); #2;
            go = 1'b0; prog_we = 1'b0;
        end
        opnd_valid = 1'b0;
    endtask

    task automatic do_run(input logic [63:0] a, input logic [63:0] b, input int len,
                          input int s1, input int s2, input bit poke,
                          input bit wr, input logic [3:0] wa, input logic [1:0] wd,
                          input bit pin, input logic [63:0] lit);
        int g = 0;
        if (wr) shadow[wa] = wd;
        predict(a, b, len);
        if (pin) check("model_pin", exp_result, lit);
        obs_ops.delete(); ie_count = 0; rv_count = 0;
        start_run(len, wr, wa, wd);
        drive_beats(a, b, s1, s2, 16, poke);
        while (rv_count == 0 && g < 100) begin @(negedge clk); #2; g++; end
        if (g == 100) check("result_timeout", 1'b0, 1'b1);
        @(negedge clk); #1;
        check("busy_drops", busy, 1'b0);
        check("rv_once", rv_count, 1);
        check("ie_beats", ie_count, 16);
        check("result_held", result, exp_result);
        check("no_err", err, 1'b0);
        check("op_count", obs_ops.size(), exp_ops.size());
        for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
            check("op_seq", obs_ops[i], exp_ops[i]);
        #1;
    endtask

    initial begin
        int n, g;
        for (int i = 0; i < 16; i++) shadow[i] = 2'd0;
        repeat (2) @(negedge clk);
        #1 check("reset_busy", busy, 1'b0);
        check("reset_result", result, '0);
        #1 rst = 1'b1;
        @(negedge clk); #2;

        // 1: empty program, drain ops 2,1 only
        do_run(64'h1, 64'h0, 0, -1, -1, 0, 0, 0, 0, 1, 64'h1);
        // 2: go with simultaneous write of mem[0]=3
        do_run(64'h1, 64'h0, 1, -1, -1, 0, 1, 4'd0, 2'd3, 1, 64'h3);
        // multi-op program
        prog_write(4'd1, 2'd2);
        prog_write(4'd2, 2'd0);
        prog_write(4'd3, 2'd3);
        do_run(64'h10, 64'h5, 4, -1, -1, 0, 0, 0, 0, 1, 64'h55);
        // 3: stalls at beats 5 and 11, nibble ordering
        do_run(64'hFEDC_BA98_7654_3210, 64'h0, 0, 5, 11, 0, 0, 0, 0, 1, 64'hFEDC_BA98_7654_3210);

        // 4: reset mid-load at beat 7
        start_run(0, 0, 0, 0);
        drive_beats(64'h1, 64'h0, -1, -1, 7, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 2'd0;
        #1 check("async_reset_quiet", {busy, opnd_ready, result_valid, err, dp_start,
                                        dp_input_enable, dp_a, dp_b, dp_op_val, result}, '0);
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2;
        do_run(64'h1, 64'h0, 0, -1, -1, 0, 0, 0, 0, 1, 64'h1);

        // 5: datapath stuck in S2 during drain
        freeze_s2 = 1'b1; rv_count = 0;
        start_run(0, 0, 0, 0);
        drive_beats(64'h1, 64'h0, -1, -1, 16, 0);
        n = 0; g = 0;
        while (busy && g < 30) begin
            if (dp_state == 4'd2) n++;
            @(negedge clk); #2; g++;
        end
        check("drain_timeout_cycles", n, 8);
        check("drain_timeout_err", err, 1'b1);
        check("drain_timeout_no_rv", rv_count, 0);
        freeze_s2 = 1'b0; stub_clr = 1'b1;
        @(negedge clk); #2 stub_clr = 1'b0;
        repeat (3) @(negedge clk);
        #2 check("err_sticky", err, 1'b1);
        do_run(64'h1, 64'h0, 0, -1, -1, 0, 0, 0, 0, 0, 0);

        // 6: writes and go while busy are ignored
        do_run(64'h1, 64'h0, 1, -1, -1, 1, 1, 4'd0, 2'd3, 1, 64'h3);
        do_run(64'h1, 64'h0, 1, -1, -1, 0, 0, 0, 0, 1, 64'h3);
        ov_input = 1'b1; rv_count = 0;
        start_run(0, 0, 0, 0);
        @(negedge clk); #2;
        check("start_err", err, 1'b1);
        check("start_err_idle", busy, 1'b0);
        check("start_err_no_rv", rv_count, 0);
        ov_input = 1'b0;
        do_run(64'h1, 64'h0, 0, -1, -1, 0, 0, 0, 0, 1, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
